// File: rtl/tow_playfield.sv
// rtl/tow_playfield.sv - tug-of-war playfield with scoring, timed hold and match end
//
// Purpose:
//   A single lit position moves left (L) or right (R) across NUM_LIGHTS lights.
//   Pushing past an edge scores for that side, darkens the field for HOLD_CYCLES
//   cycles, then re-centres. The match ends when either score reaches its
//   all-ones value; the field then stays dark until Reset.
//
// Optional feature:
//   TOW_KEY_EDGE_EN - when defined, keys pass through a registered rising-edge
//   detector so a held key makes a single move or point (adds 1 cycle latency).
//
// Ports:
//   Clock        in   system clock
//   Reset        in   synchronous, active-high reset
//   L, R         in   synchronised left / right keys
//   lights       out  field LEDs, bit 0 = rightmost, bit NUM_LIGHTS-1 = leftmost
//   left_score   out  points won by the left player
//   right_score  out  points won by the right player
//   point_l      out  one-cycle pulse when left scores
//   point_r      out  one-cycle pulse when right scores
//   game_over    out  high once either score saturates

module tow_playfield #(
  parameter int NUM_LIGHTS  = 9,
  parameter int SCORE_W     = 3,
  parameter int HOLD_CYCLES = 4
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  L,
  input  logic                  R,
  output logic [NUM_LIGHTS-1:0] lights,
  output logic [SCORE_W-1:0]    left_score,
  output logic [SCORE_W-1:0]    right_score,
  output logic                  point_l,
  output logic                  point_r,
  output logic                  game_over
);

  localparam int PW = (NUM_LIGHTS > 1) ? $clog2(NUM_LIGHTS) : 1;
  localparam int HW = $clog2(HOLD_CYCLES + 1);

  localparam logic [PW-1:0]      POS_MAX   = PW'(NUM_LIGHTS - 1);
  localparam logic [PW-1:0]      CTR       = PW'((NUM_LIGHTS - 1) / 2);
  localparam logic [HW-1:0]      HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [SCORE_W-1:0] SMAX      = {SCORE_W{1'b1}};

  typedef enum logic [1:0] {PLAY, HOLD, OVER} state_t;

  state_t        state;
  logic [PW-1:0] pos;
  logic [HW-1:0] hold_cnt;
  logic          mv_l;
  logic          mv_r;

  function automatic logic [NUM_LIGHTS-1:0] onehot(input logic [PW-1:0] p);
    onehot = {{(NUM_LIGHTS-1){1'b0}}, 1'b1} << p;
  endfunction

`ifdef TOW_KEY_EDGE_EN
  // Edge pulses are themselves registered, giving one extra cycle of latency.
  logic l_d, r_d, l_edge, r_edge;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      l_d    <= 1'b0;
      r_d    <= 1'b0;
      l_edge <= 1'b0;
      r_edge <= 1'b0;
    end else begin
      l_d    <= L;
      r_d    <= R;
      l_edge <= L & ~l_d;
      r_edge <= R & ~r_d;
    end
  end

  assign mv_l = l_edge & ~r_edge;
  assign mv_r = r_edge & ~l_edge;
`else
  // Both keys together cancel out.
  assign mv_l = L & ~R;
  assign mv_r = R & ~L;
`endif

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state       <= PLAY;
      pos         <= CTR;
      hold_cnt    <= '0;
      lights      <= onehot(CTR);
      left_score  <= '0;
      right_score <= '0;
      point_l     <= 1'b0;
      point_r     <= 1'b0;
      game_over   <= 1'b0;
    end else begin
      point_l <= 1'b0;
      point_r <= 1'b0;
      case (state)
        PLAY: begin
          if (mv_l) begin
            if (pos == POS_MAX) begin
              left_score <= left_score + SCORE_W'(1);
              point_l    <= 1'b1;
              lights     <= '0;
              hold_cnt   <= '0;
              // Entering OVER at the maximum is what keeps scores from wrapping.
              if (left_score == SMAX - SCORE_W'(1)) begin
                state     <= OVER;
                game_over <= 1'b1;
              end else begin
                state <= HOLD;
              end
            end else begin
              pos    <= pos + PW'(1);
              lights <= onehot(pos + PW'(1));
            end
          end else if (mv_r) begin
            if (pos == '0) begin
              right_score <= right_score + SCORE_W'(1);
              point_r     <= 1'b1;
              lights      <= '0;
              hold_cnt    <= '0;
              if (right_score == SMAX - SCORE_W'(1)) begin
                state     <= OVER;
                game_over <= 1'b1;
              end else begin
                state <= HOLD;
              end
            end else begin
              pos    <= pos - PW'(1);
              lights <= onehot(pos - PW'(1));
            end
          end
        end
        HOLD: begin
          // The scoring edge already darkened the field; that counts as hold cycle 0.
          if (hold_cnt == HOLD_LAST) begin
            state    <= PLAY;
            pos      <= CTR;
            lights   <= onehot(CTR);
            hold_cnt <= '0;
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        OVER: begin
          lights    <= '0;
          game_over <= 1'b1;
        end
        default: begin
          state <= PLAY;
        end
      endcase
    end
  end

endmodule

// File: doc/tow_playfield.md
Name: tow_playfield

Overview:
- Complete tug-of-war playfield generalised to NUM_LIGHTS positions.
- A single lit position moves left or right on key presses. Pushing past an edge scores a point for that side.
- After a point, a timed hold runs, then the field re-centres automatically. The match ends when either score saturates.
- Sits between the synchronised key inputs and the LED/HEX display drivers.

Parameters:
- NUM_LIGHTS, 9, number of field lights; odd, >= 3.
- SCORE_W, 3, width of each score counter; the match ends when a score reaches 2**SCORE_W-1.
- HOLD_CYCLES, 4, number of cycles the field stays dark after a point before re-centring; >= 1.

Ports:
- Clock  input  1  system clock.
- Reset  input  1  synchronous, active-high reset; clock Clock.
- L  input  1  left key, already synchronised upstream.
- R  input  1  right key, already synchronised upstream.
- lights  output  NUM_LIGHTS  field LEDs; bit 0 = rightmost, bit NUM_LIGHTS-1 = leftmost.
- left_score  output  SCORE_W  points won by the left player.
- right_score  output  SCORE_W  points won by the right player.
- point_l  output  1  one-cycle pulse when left scores.
- point_r  output  1  one-cycle pulse when right scores.
- game_over  output  1  high once either score saturates.

Behaviour:
- Internal position pos, 0..NUM_LIGHTS-1. CTR = (NUM_LIGHTS-1)/2.
- Reset values: pos=CTR, state=PLAY, lights=one-hot at CTR, both scores 0, point_l=point_r=0, game_over=0, hold counter 0. Reset has priority over everything and is honoured in every state.
- Key decode: mvL = L & ~R; mvR = R & ~L. L&R and ~L&~R both mean no move.
- States: PLAY, HOLD, OVER.
- PLAY, pos < NUM_LIGHTS-1 and mvL: pos <= pos+1.
- PLAY, pos > 0 and mvR: pos <= pos-1.
- Lights reflect a move on the next clock edge (1-cycle latency). lights is a registered one-hot of pos in PLAY.
- PLAY, pos == NUM_LIGHTS-1 and mvL: left scores.
  - left_score increments; point_l is high for exactly the next cycle.
  - If the new score == 2**SCORE_W-1, go to OVER; otherwise go to HOLD.
- PLAY, pos == 0 and mvR: symmetric for the right player (right_score, point_r).
- Only one point per cycle is possible (mvL and mvR are mutually exclusive).
- HOLD:
  - lights all 0; keys ignored; the hold counter counts HOLD_CYCLES cycles.
  - On the last hold cycle: pos <= CTR and state <= PLAY. Centre light is on in the following cycle.
  - Scores unchanged.
- OVER:
  - lights all 0; game_over=1; keys ignored.
  - Scores frozen at their final values; stays in OVER until Reset.
- Scores never wrap. Saturation is guaranteed because OVER is entered when the maximum is reached.
- Reset asserted mid-HOLD or in OVER returns to the full reset state on the next edge.
- Keys are sampled every cycle. With the optional feature off, a key held high moves the light once per cycle.

Optional Feature:
- Macro: TOW_KEY_EDGE_EN.
- Defined:
  - L and R each pass through a registered rising-edge detector; mvL/mvR are derived from the edge pulses.
  - A held key produces one move or point only.
  - Edge registers clear to 0 on Reset. A key already high when Reset releases yields one edge on the first cycle after release.
  - Adds 1 cycle of key-to-light latency (2 total).
- Undefined: raw levels are used exactly as in Behaviour.

Test Plan (NUM_LIGHTS=5, SCORE_W=2, HOLD_CYCLES=4, macro undefined unless stated):
- Reset, then idle 3 cycles -> lights=5'b00100, scores 0, game_over=0.
- L=1 for 1 cycle, then L=1,R=1 for 1 cycle, then R=1 for 1 cycle:
  - lights 00100 -> 01000 -> 01000 -> 00100.
- L=1 for 3 cycles from centre:
  - lights 01000, 10000, then left_score=1, point_l pulse, lights=00000 for 4 cycles, then 00100.
- Right player scores 3 times:
  - right_score=3, game_over=1, lights=00000.
  - Further L/R presses change nothing.
  - Reset -> lights=00100, scores 0.
- Reset asserted in the 2nd HOLD cycle -> next cycle: lights=00100, left_score=0, state PLAY.
- TOW_KEY_EDGE_EN defined, L held high for 10 cycles from centre -> single move to 01000, no point scored.
